// File: rtl/rv32im_types.sv
// Shared result-bus types and functional-unit source indices for the RV32IM core.
package rv32im_types;

    localparam int unsigned CDB_ALU    = 32'd0;
    localparam int unsigned CDB_MULDIV = 32'd1;
    localparam int unsigned CDB_LSQ    = 32'd2;
    localparam int unsigned CDB_BR     = 32'd3;

    // Tag field sized for the deepest supported ROB (64 entries); narrower tags are zero-extended.
    localparam int unsigned CDB_TAG_W = 32'd6;

    typedef struct packed {
        logic                 valid;
        logic [CDB_TAG_W-1:0] tag;
        logic [31:0]          data;
    } cdb_pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] pos_s;

    // Scan requesters starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        pos_s       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos_s = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!grant_valid && req[pos_s]) begin
                grant[pos_s] = 1'b1;
                grant_idx    = pos_s;
                grant_valid  = 1'b1;
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding register per functional unit, one broadcast per cycle.
// Define CDB_ARB_BRANCH_PRIO_EN to give the branch unit (NUM_REQ-1) fixed priority.
module cdb_arbiter
    import rv32im_types::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int ROB_DEPTH = 8,
    localparam int TAG_W     = $clog2(ROB_DEPTH),
    localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [TAG_W-1:0]   req_tag  [NUM_REQ],
    input  logic [31:0]        req_data [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ready,
    output logic               cdb_valid,
    output logic [TAG_W-1:0]   cdb_tag,
    output logic [31:0]        cdb_data,
    output logic [SRC_W-1:0]   cdb_src
);

    cdb_pkt_t           hold_q [NUM_REQ];
    cdb_pkt_t           hold_d [NUM_REQ];
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] pend_s, arb_grant_s, grant_s;
    logic [SRC_W-1:0]   arb_idx_s, grant_idx_s;
    logic               arb_valid_s, grant_valid_s, prio_s;
    cdb_pkt_t           bcast_s;

    // Pending vector for the round-robin search.
    always_comb begin
        pend_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend_s[i] = hold_q[i].valid;
        end
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(SRC_W)) u_rr (
        .req         (pend_s),
        .ptr         (rr_ptr_q),
        .grant       (arb_grant_s),
        .grant_idx   (arb_idx_s),
        .grant_valid (arb_valid_s)
    );

    // Final grant: flush suppresses everything; branch may pre-empt round-robin.
    always_comb begin
        grant_s       = '0;
        grant_idx_s   = '0;
        grant_valid_s = 1'b0;
        prio_s        = 1'b0;
        if (flush) begin
            grant_valid_s = 1'b0;
        end
`ifdef CDB_ARB_BRANCH_PRIO_EN
        else if (pend_s[NUM_REQ-1]) begin
            grant_s[NUM_REQ-1] = 1'b1;
            grant_idx_s        = SRC_W'(NUM_REQ - 1);
            grant_valid_s      = 1'b1;
            prio_s             = 1'b1;
        end
`endif
        else begin
            grant_s       = arb_grant_s;
            grant_idx_s   = arb_idx_s;
            grant_valid_s = arb_valid_s;
        end
    end

    // A granted register drains this cycle, so it can take a new offer at the same edge.
    assign req_ready = {NUM_REQ{!flush}} & (~pend_s | grant_s);

    // Holding-register and pointer next state.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            hold_d[i] = hold_q[i];
            if (flush) begin
                hold_d[i].valid = 1'b0;
            end else if (req_valid[i] && req_ready[i]) begin
                hold_d[i] = '{valid: 1'b1, tag: CDB_TAG_W'(req_tag[i]), data: req_data[i]};
            end else if (grant_s[i]) begin
                hold_d[i].valid = 1'b0;
            end else begin
                hold_d[i] = hold_q[i];
            end
        end
        if (grant_valid_s && !prio_s) begin
            rr_ptr_d = (grant_idx_s == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + SRC_W'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // State registers; reset wins over flush and discards held results.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_q[i] <= '0;
            end
            rr_ptr_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_q[i] <= hold_d[i];
            end
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Broadcast mux; all fields read zero when nothing is granted.
    always_comb begin
        if (grant_valid_s) begin
            bcast_s = hold_q[grant_idx_s];
        end else begin
            bcast_s = '0;
        end
    end

    assign cdb_valid = bcast_s.valid;
    assign cdb_tag   = TAG_W'(bcast_s.tag);
    assign cdb_data  = bcast_s.data;
    assign cdb_src   = grant_valid_s ? grant_idx_s : '0;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic against a queue-level model.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 3;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst, flush;
    logic [N-1:0]  req_valid, req_ready;
    logic [TW-1:0] req_tag  [N];
    logic [31:0]   req_data [N];
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [31:0]   cdb_data;
    logic [SW-1:0] cdb_src;

    cdb_arbiter #(.NUM_REQ(N), .ROB_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data), .req_ready(req_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: one slot per requester plus the round-robin start position.
    bit          m_full [N];
    logic [TW-1:0] m_tag [N];
    logic [31:0] m_data [N];
    int          m_ptr;

    // Values observed in the most recent step, for hand-computed expectations.
    logic        o_cv;
    logic [31:0] o_tag, o_data, o_src;
    logic [N-1:0] o_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_pick();
        if (flush) return -1;
`ifdef CDB_ARB_BRANCH_PRIO_EN
        if (m_full[N-1]) return N - 1;
`endif
        for (int k = 0; k < N; k++) begin
            if (m_full[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic step();
        int g;
        logic [N-1:0] er;
        @(negedge clk);
        g = model_pick();
        for (int i = 0; i < N; i++) er[i] = !flush && (!m_full[i] || g == i);
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("cdb_valid", 32'(cdb_valid), (g >= 0) ? 32'd1 : 32'd0);
        chk("cdb_tag",  32'(cdb_tag),  (g >= 0) ? 32'(m_tag[g]) : 32'd0);
        chk("cdb_data", cdb_data,      (g >= 0) ? m_data[g] : 32'd0);
        chk("cdb_src",  32'(cdb_src),  (g >= 0) ? 32'(g) : 32'd0);
        o_cv = cdb_valid; o_tag = 32'(cdb_tag); o_data = cdb_data;
        o_src = 32'(cdb_src); o_ready = req_ready;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) m_full[i] = 1'b0;
            m_ptr = 0;
        end else if (flush) begin
            for (int i = 0; i < N; i++) m_full[i] = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && er[i]) begin
                    m_full[i] = 1'b1; m_tag[i] = req_tag[i]; m_data[i] = req_data[i];
                end else if (g == i) begin
                    m_full[i] = 1'b0;
                end
            end
`ifdef CDB_ARB_BRANCH_PRIO_EN
            if (g >= 0 && g != N - 1) m_ptr = (g + 1) % N;
`else
            if (g >= 0) m_ptr = (g + 1) % N;
`endif
        end
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; req_valid = '0;
    endtask

    task automatic offer(input int i, input logic [TW-1:0] t, input logic [31:0] d);
        req_valid[i] = 1'b1; req_tag[i] = t; req_data[i] = d;
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; step(); rst = 1'b0;
    endtask

    int exp_order [N];

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = '0;
        for (int i = 0; i < N; i++) begin req_tag[i] = '0; req_data[i] = 32'd0; end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin m_full[i] = 1'b0; m_tag[i] = '0; m_data[i] = 32'd0; end
        m_ptr = 0;

        // Reset state and single-result latency.
        do_reset();
        idle(); step();
        chk("rst_cdb_valid", 32'(o_cv), 32'd0);
        chk("rst_cdb_src", o_src, 32'd0);
        chk("rst_ready", 32'(o_ready), 32'hF);
        offer(0, 3'd3, 32'hDEADBEEF); step();
        idle(); step();
        chk("single_valid", 32'(o_cv), 32'd1);
        chk("single_tag", o_tag, 32'd3);
        chk("single_data", o_data, 32'hDEADBEEF);
        chk("single_src", o_src, 32'd0);
        step();
        chk("single_after", 32'(o_cv), 32'd0);

        // All four at once from pointer 0.
        do_reset();
        for (int i = 0; i < N; i++) offer(i, TW'(i), 32'h100 + 32'(i));
        step(); idle();
`ifdef CDB_ARB_BRANCH_PRIO_EN
        exp_order = '{3, 0, 1, 2};
`else
        exp_order = '{0, 1, 2, 3};
`endif
        for (int k = 0; k < N; k++) begin
            step();
            chk("all4_src", o_src, 32'(exp_order[k]));
            chk("all4_tag", o_tag, 32'(exp_order[k]));
        end
        step();
        chk("all4_done", 32'(o_cv), 32'd0);

        // Back-pressure on a held, ungranted requester.
        do_reset();
        offer(0, 3'd1, 32'hA0); offer(1, 3'd2, 32'hA1); step();
        idle(); offer(1, 3'd5, 32'h55); step();
        chk("bp_src0", o_src, 32'd0);
        chk("bp_ready1_low", 32'(o_ready[1]), 32'd0);
        step();
        chk("bp_src1", o_src, 32'd1);
        chk("bp_ready1_high", 32'(o_ready[1]), 32'd1);
        chk("bp_old_data", o_data, 32'hA1);
        idle(); step();
        chk("bp_new_tag", o_tag, 32'd5);
        chk("bp_new_data", o_data, 32'h55);

        // Flush with three held; pointer sits at 2 and must survive.
        offer(0, 3'd1, 32'hF0); offer(1, 3'd2, 32'hF1); offer(2, 3'd3, 32'hF2); step();
        idle(); flush = 1'b1; step();
        chk("flush_cv", 32'(o_cv), 32'd0);
        chk("flush_ready", 32'(o_ready), 32'h0);
        idle(); step();
        chk("flush_next_cv", 32'(o_cv), 32'd0);
        offer(0, 3'd4, 32'hB0); offer(2, 3'd6, 32'hB2); step();
        idle(); step();
        chk("flush_ptr_kept", o_src, 32'd2);
        step();
        chk("flush_ptr_next", o_src, 32'd0);

        // Wrap from pointer 3 to 0.
        offer(2, 3'd7, 32'hC2); step(); idle(); step();
        offer(3, 3'd1, 32'hC3); offer(0, 3'd2, 32'hC0); step(); idle();
        step(); chk("wrap_first", o_src, 32'd3);
        step(); chk("wrap_second", o_src, 32'd0);
        offer(0, 3'd3, 32'hD0); offer(1, 3'd4, 32'hD1); step(); idle();
        step(); chk("wrap_ptr1", o_src, 32'd1);
        step(); chk("wrap_ptr1_next", o_src, 32'd0);
        step(); chk("wrap_empty", 32'(o_cv), 32'd0);

`ifdef CDB_ARB_BRANCH_PRIO_EN
        // Branch held continuously starves the ALU.
        do_reset();
        offer(0, 3'd1, 32'hE0); offer(3, 3'd2, 32'hE3); step();
        for (int k = 0; k < 6; k++) begin
            step();
            chk("prio_src", o_src, 32'd3);
        end
        req_valid[3] = 1'b0; step();
        idle(); step();
        chk("prio_alu_after", o_src, 32'd0);
`endif

        // Randomized traffic with sporadic flush and reset.
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 19) == 0);
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_tag[i]  = TW'($urandom);
                req_data[i] = $urandom;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, the number of functional-unit requesters (alu 0, mul_div 1, load_store 2, branch 3).
REQ-002 SHALL have parameter ROB_DEPTH, default 8; the tag width is $clog2(ROB_DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1 bit: the pipeline flush from commit.
REQ-006 SHALL have port req_valid[NUM_REQ], input, 1 bit each: a requester offers a result.
REQ-007 SHALL have port req_tag[NUM_REQ], input, tag width each: the ROB tag of the offered result.
REQ-008 SHALL have port req_data[NUM_REQ], input, 32 bits each: the result value.
REQ-009 SHALL have port req_ready[NUM_REQ], output, 1 bit each: the arbiter accepts the offer this cycle.
REQ-010 SHALL have port cdb_valid, output, 1 bit: the broadcast is valid this cycle.
REQ-011 SHALL have port cdb_tag, output, tag width: the broadcast tag.
REQ-012 SHALL have port cdb_data, output, 32 bits: the broadcast value.
REQ-013 SHALL have port cdb_src, output, $clog2(NUM_REQ) bits: the index of the granted requester.

Function
REQ-014 SHALL hold one holding register per requester (valid, tag, data).
REQ-015 SHALL load the holding register on the clk edge when req_valid[i] & req_ready[i] and flush is 0.
REQ-016 SHALL drive req_ready[i] = !flush & (!hold_valid[i] | grant[i]), allowing same-cycle drain and refill.
REQ-017 SHALL grant, each cycle, at most one requester whose hold_valid is 1, chosen round-robin starting at rr_ptr.
REQ-018 SHALL drive cdb_valid = (any hold_valid) & !flush, combinationally; cdb_tag, cdb_data and cdb_src come from the granted register.
REQ-019 SHALL drive cdb_tag, cdb_data and cdb_src to 0 when cdb_valid is 0.
REQ-020 SHALL clear the granted hold_valid at the edge, unless it is refilled in the same cycle per REQ-016.
REQ-021 SHALL update rr_ptr to (granted index + 1) mod NUM_REQ after a grant, wrapping from NUM_REQ-1 to 0; it is unchanged when there is no grant.
REQ-022 SHALL give a minimum latency of 1 cycle from a req handshake to cdb_valid.
REQ-023 SHALL give each pending entry a maximum wait of NUM_REQ-1 cycles under round-robin.
REQ-024 SHALL, when flush=1, clear all hold_valid at the edge, drop any handshake in that cycle, grant nothing, and leave rr_ptr unchanged.
REQ-025 SHALL give rst priority over flush.
REQ-026 SHALL never broadcast the same held entry twice.
REQ-027 SHALL never reorder entries from the same requester.

Reset
REQ-028 SHALL, on rst, clear all hold_valid and set rr_ptr = 0 at the clk edge.
REQ-029 SHALL, in the cycle after rst, present cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, and req_ready all 1.
REQ-030 SHALL discard any data held when rst asserts mid-operation.

Configuration
REQ-031 SHALL, with CDB_ARB_BRANCH_PRIO_EN defined, always grant requester NUM_REQ-1 (branch) when its hold_valid=1.
REQ-032 SHALL, in that prioritised case, leave rr_ptr unchanged; the other requesters use round-robin only when branch is idle.
REQ-033 SHALL, without CDB_ARB_BRANCH_PRIO_EN, use pure round-robin with no fixed priority.

Structure
REQ-034 SHALL take the CDB source index constants (CDB_ALU=0, CDB_MULDIV=1, CDB_LSQ=2, CDB_BR=3) and the cdb_pkt_t typedef (valid, tag, data) from rv32im_types.
REQ-035 SHALL use one sub-module, rr_arbiter (request vector, pointer in; one-hot grant and index out), which is combinational and parameterised by NUM_REQ.

Verification
REQ-036 SHALL cover: rst, then req_valid[0]=1, tag=3, data=0xDEADBEEF -> next cycle cdb_valid=1, cdb_tag=3, cdb_data=0xDEADBEEF, cdb_src=0; following cycle cdb_valid=0.
REQ-037 SHALL cover: all 4 requesters handshake in the same cycle, tags 0..3, rr_ptr=0 -> over the next 4 cycles cdb_src=0,1,2,3 in order, then cdb_valid=0.
REQ-038 SHALL cover: requester 1 held and not granted, req_valid[1] again -> req_ready[1]=0; once granted, req_ready[1]=1 in the same cycle and the new data broadcasts in a later cycle.
REQ-039 SHALL cover: 3 entries held, flush=1 for one cycle -> cdb_valid=0 that cycle and the next; no held tag ever broadcasts; rr_ptr is unchanged.
REQ-040 SHALL cover: rr_ptr=3 and requesters 3 and 0 pending -> grant order 3 then 0, rr_ptr=1 afterwards.
REQ-041 SHALL cover, with CDB_ARB_BRANCH_PRIO_EN: requesters 0 and 3 continuously valid -> cdb_src=3 every cycle it is held; requester 0 broadcasts only in cycles where requester 3's register is empty.
